// File: rtl/ldl_evt_pend_v1_if.sv
// Bus bundle for the pending-event collector: event inputs, pending status
// and the served-index valid/ready slot.
interface ldl_evt_pend_v1_if #(
  parameter int BIN_WIDTH = 4,
  parameter int HOT_WIDTH = 1 << BIN_WIDTH,
  parameter int CNT_WIDTH = 8
);
  logic [HOT_WIDTH-1:0] evt;
  logic [HOT_WIDTH-1:0] mask;
  logic                 flush;
  logic [HOT_WIDTH-1:0] pend;
  logic                 pend_any;
  logic                 o_valid;
  logic                 o_ready;
  logic [BIN_WIDTH-1:0] o_idx;
  logic [CNT_WIDTH-1:0] drop_cnt;

  // Event producer / index consumer side
  modport master (
    output evt, mask, flush, o_ready,
    input  pend, pend_any, o_valid, o_idx, drop_cnt
  );

  // Collector side
  modport slave (
    input  evt, mask, flush, o_ready,
    output pend, pend_any, o_valid, o_idx, drop_cnt
  );
endinterface

// File: rtl/ldl_evt_pend_v1.sv
// Pending-event collector: latches event pulses into sticky pending bits and
// serves them lowest-index-first as a binary index over valid/ready.
module ldl_evt_pend_v1 #(
  parameter int BIN_WIDTH = 4,
  parameter int HOT_WIDTH = 1 << BIN_WIDTH,
  parameter int CNT_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  ldl_evt_pend_v1_if.slave bus
);

  logic [HOT_WIDTH-1:0] pend_q;
  logic                 pend_any_q;
  logic                 valid_q;
  logic [BIN_WIDTH-1:0] idx_q;
  logic [CNT_WIDTH-1:0] drop_q;

  logic [HOT_WIDTH-1:0] acc;
  logic [HOT_WIDTH-1:0] clr;
  logic [HOT_WIDTH-1:0] pend_next;
  logic [HOT_WIDTH-1:0] drop_vec;
  logic [BIN_WIDTH-1:0] sel;
  logic                 load;

  // Scanning downward lets the lowest set bit overwrite higher ones.
  always_comb begin
    sel = '0;
    for (int i = HOT_WIDTH - 1; i >= 0; i--) begin
      if (pend_q[i]) sel = BIN_WIDTH'(i);
    end
  end

  // A new event on the bit being loaded re-arms it rather than counting as a drop.
  always_comb begin
    acc       = bus.evt & ~bus.mask;
    load      = pend_any_q & (~valid_q | bus.o_ready);
    clr       = load ? (HOT_WIDTH'(1) << sel) : '0;
    pend_next = (pend_q & ~clr) | acc;
    drop_vec  = acc & pend_q & ~clr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      pend_any_q <= 1'b0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      drop_q     <= '0;
    end else if (bus.flush) begin
      pend_q     <= '0;
      pend_any_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      pend_q     <= pend_next;
      pend_any_q <= |pend_next;
      if (load) begin
        idx_q   <= sel;
        valid_q <= 1'b1;
      end else if (valid_q & bus.o_ready) begin
        valid_q <= 1'b0;
      end
      if ((|drop_vec) && (drop_q != '1)) drop_q <= drop_q + CNT_WIDTH'(1);
    end
  end

  assign bus.pend     = pend_q;
  assign bus.pend_any = pend_any_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_idx    = idx_q;
  assign bus.drop_cnt = drop_q;

endmodule
